// File: rtl/ym_pkg.sv
// Shared types and constants for the TurboSound bus scheduler.
package ym_pkg;

  // Request kinds as presented by the port decoder.
  typedef enum logic [1:0] {
    KIND_ADDR = 2'd0,
    KIND_DATA = 2'd1,
    KIND_READ = 2'd2,
    KIND_NONE = 2'd3
  } req_kind_e;

  // Bus codes as {BDIR, BC1}.
  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_ADDR  = 2'b11;
  localparam logic [1:0] CODE_WRITE = 2'b10;
  localparam logic [1:0] CODE_READ  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } bus_state_e;

  // One queued command: kind in the top bits, byte below.
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Two chips, four register writes each, address + data cycle per write.
  localparam int INIT_STEPS = 16;

  // Silence table: {register, value}; rows 0-3 for chip 0, rows 4-7 for chip 1.
  localparam logic [15:0] INIT_TABLE [0:7] = '{
    16'h07FF, 16'h0800, 16'h0900, 16'h0A00,
    16'h07FF, 16'h0800, 16'h0900, 16'h0A00
  };

  // Address writes of 0xF8..0xFF select a chip instead of reaching the bus.
  function automatic logic is_chip_select(input cmd_t cmd);
    return (cmd.kind == KIND_ADDR) && (cmd.data[7:3] == 5'b11111);
  endfunction

endpackage

// File: rtl/ym_cmd_fifo.sv
// Small synchronous FIFO with show-ahead head so a pop can launch a bus
// cycle in the same clock it is decided. A push while full is accepted
// only if a pop happens in the same cycle.
module ym_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             cpu_clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge cpu_clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ym_bus_scheduler.sv
// Serialises CPU accesses and the post-reset silence sequence onto the
// shared dual-YM2149 bus with SETUP / STROBE / RECOVER timing.
module ym_bus_scheduler
  import ym_pkg::*;
#(
  parameter int STROBE_CYC = 3,
  parameter int FIFO_DEPTH = 4,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       req_stb,
  input  logic [1:0] req_kind,
  input  logic [7:0] req_data,
  output logic       q_full,
  output logic       ovf,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       ym_bdir,
  output logic       ym_bc1,
  output logic [7:0] ym_da_out,
  output logic       ym_da_oe,
  input  logic [7:0] ym_da_in,
  output logic       ym_sel0,
  output logic       ym_sel1
);

  bus_state_e state_reg, state_next;
  logic [3:0] strobe_cnt_reg;
  logic [1:0] cur_kind_reg;
  logic [7:0] cur_data_reg;
  logic       chip_sel_reg;
  logic       init_active_reg;
  logic [4:0] init_idx_reg;
  logic [7:0] rd_data_reg;
  logic       rd_valid_reg;
  logic       ovf_reg;

  cmd_t       push_cmd, head_cmd, launch_cmd;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       launch, cs_cmd, init_step, init_finish, strobe_last;
  logic [15:0] init_pair;
  logic [1:0] bus_code;

  assign push_cmd    = {req_kind, req_data};
  assign fifo_push   = req_stb && (req_kind != KIND_NONE);
  assign strobe_last = (strobe_cnt_reg == 4'(STROBE_CYC - 1));
  assign init_pair   = INIT_TABLE[init_idx_reg[3:1]];

  ym_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Bus state register.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next state plus the IDLE-time arbitration: init first, then the queue.
  always_comb begin
    state_next  = state_reg;
    launch      = 1'b0;
    launch_cmd  = '0;
    fifo_pop    = 1'b0;
    cs_cmd      = 1'b0;
    init_step   = 1'b0;
    init_finish = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (init_active_reg) begin
          if (init_idx_reg == 5'(INIT_STEPS)) begin
            init_finish = 1'b1;
          end else begin
            init_step       = 1'b1;
            launch          = 1'b1;
            launch_cmd.kind = init_idx_reg[0] ? KIND_DATA : KIND_ADDR;
            launch_cmd.data = init_idx_reg[0] ? init_pair[7:0] : init_pair[15:8];
          end
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (is_chip_select(head_cmd)) begin
            cs_cmd = 1'b1;
          end else begin
            launch     = 1'b1;
            launch_cmd = head_cmd;
          end
        end
        if (launch) state_next = ST_SETUP;
      end
      ST_SETUP:   state_next = ST_STROBE;
      ST_STROBE:  if (strobe_last) state_next = ST_RECOVER;
      ST_RECOVER: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Datapath: latched command, chip select, init progress, read capture, overflow.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      strobe_cnt_reg  <= '0;
      cur_kind_reg    <= KIND_ADDR;
      cur_data_reg    <= '0;
      chip_sel_reg    <= 1'b0;
      init_active_reg <= INIT_EN;
      init_idx_reg    <= '0;
      rd_data_reg     <= '0;
      rd_valid_reg    <= 1'b0;
      ovf_reg         <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      if (launch) begin
        cur_kind_reg <= launch_cmd.kind;
        cur_data_reg <= launch_cmd.data;
      end
      if (init_step) begin
        init_idx_reg <= init_idx_reg + 5'd1;
        chip_sel_reg <= init_idx_reg[3];
      end
      if (cs_cmd) chip_sel_reg <= head_cmd.data[0];
      if (init_finish) begin
        init_active_reg <= 1'b0;
        chip_sel_reg    <= 1'b0;
      end
      if (state_reg == ST_STROBE && !strobe_last) strobe_cnt_reg <= strobe_cnt_reg + 4'd1;
      else                                        strobe_cnt_reg <= '0;
      if (state_reg == ST_STROBE && strobe_last && cur_kind_reg == KIND_READ) begin
        rd_data_reg  <= ym_da_in;
        rd_valid_reg <= 1'b1;
      end
      if (fifo_push && fifo_full && !fifo_pop) ovf_reg <= 1'b1;
    end
  end

  // Bus pin decode from state; reads never drive the data bus.
  always_comb begin
    bus_code = CODE_IDLE;
    ym_da_oe = 1'b0;
    if (state_reg == ST_STROBE) begin
      case (cur_kind_reg)
        KIND_ADDR: bus_code = CODE_ADDR;
        KIND_DATA: bus_code = CODE_WRITE;
        KIND_READ: bus_code = CODE_READ;
        default:   bus_code = CODE_IDLE;
      endcase
    end
    if (state_reg != ST_IDLE && cur_kind_reg != KIND_READ) ym_da_oe = 1'b1;
  end

  assign {ym_bdir, ym_bc1} = bus_code;
  assign ym_da_out = cur_data_reg;
  assign ym_sel0   = ~chip_sel_reg;
  assign ym_sel1   = chip_sel_reg;
  assign q_full    = fifo_full;
  assign ovf       = ovf_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign busy      = init_active_reg || !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ym_bus_scheduler.sv
// Directed bench for ym_bus_scheduler: init sequence, timing, chip select,
// reads, overflow and asynchronous reset.
module tb_ym_bus_scheduler;

  logic       cpu_clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_stb = 1'b0;
  logic [1:0] req_kind = 2'd0;
  logic [7:0] req_data = 8'h00;
  logic [7:0] ym_da_in = 8'h00;
  logic       q_full, ovf, busy, rd_valid, ym_bdir, ym_bc1, ym_da_oe, ym_sel0, ym_sel1;
  logic [7:0] rd_data, ym_da_out;

  int checks = 0;
  int fails  = 0;

  // Bus cycle log, filled by the monitor below.
  logic [1:0] mon_prev = 2'b00;
  logic [1:0] mon_code [$];
  logic [7:0] mon_data [$];
  logic       mon_sel0 [$];
  logic       mon_oe   [$];
  int         mon_len  [$];
  int         oe_seen  = 0;
  int         rv_count = 0;

  logic [7:0] init_exp [0:15];

  ym_bus_scheduler #(.STROBE_CYC(3), .FIFO_DEPTH(4), .INIT_EN(1'b1)) dut (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .req_stb   (req_stb),
    .req_kind  (req_kind),
    .req_data  (req_data),
    .q_full    (q_full),
    .ovf       (ovf),
    .busy      (busy),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .ym_bdir   (ym_bdir),
    .ym_bc1    (ym_bc1),
    .ym_da_out (ym_da_out),
    .ym_da_oe  (ym_da_oe),
    .ym_da_in  (ym_da_in),
    .ym_sel0   (ym_sel0),
    .ym_sel1   (ym_sel1)
  );

  always #5 cpu_clock = ~cpu_clock;

  // Log one entry per bus cycle at the start of its strobe.
  always @(negedge cpu_clock) begin
    logic [1:0] cur;
    cur = {ym_bdir, ym_bc1};
    if (cur != 2'b00 && mon_prev == 2'b00) begin
      mon_code.push_back(cur);
      mon_data.push_back(ym_da_out);
      mon_sel0.push_back(ym_sel0);
      mon_oe.push_back(ym_da_oe);
      mon_len.push_back(1);
      $display("bus cycle %0d: code=%b data=%h sel0=%b oe=%b", mon_code.size() - 1, cur, ym_da_out, ym_sel0, ym_da_oe);
    end else if (cur != 2'b00 && cur == mon_prev && mon_len.size() > 0) begin
      mon_len[mon_len.size() - 1] += 1;
    end
    if (ym_da_oe) oe_seen++;
    if (rd_valid) rv_count++;
    mon_prev = cur;
  end

  task automatic clear_monitor();
    mon_code.delete();
    mon_data.delete();
    mon_sel0.delete();
    mon_oe.delete();
    mon_len.delete();
  endtask

  // Drive one request for one cycle; called at a falling edge.
  task automatic send_req(input logic [1:0] k, input logic [7:0] d);
    req_stb  = 1'b1;
    req_kind = k;
    req_data = d;
    @(negedge cpu_clock);
    req_stb  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge cpu_clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge cpu_clock);
    checks++; if ({ym_bdir, ym_bc1} !== 2'b00) begin fails++; $display("FAIL reset_code: got %b required 00", {ym_bdir, ym_bc1}); end
    checks++; if (ym_da_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b required 0", ym_da_oe); end
    checks++; if (ym_da_out !== 8'h00) begin fails++; $display("FAIL reset_da_out: got %h required 00", ym_da_out); end
    checks++; if ({rd_data, rd_valid} !== 9'h000) begin fails++; $display("FAIL reset_rd: got %h/%b required 00/0", rd_data, rd_valid); end
    checks++; if ({q_full, ovf} !== 2'b00) begin fails++; $display("FAIL reset_flags: got q_full=%b ovf=%b required 0/0", q_full, ovf); end
    checks++; if ({ym_sel0, ym_sel1} !== 2'b10) begin fails++; $display("FAIL reset_sel: got %b%b required 10", ym_sel0, ym_sel1); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b required 1", busy); end
  endtask

  task automatic test_init();
    init_exp = '{8'h07, 8'hFF, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h00,
                 8'h07, 8'hFF, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h00};
    clear_monitor();
    reset = 1'b1;
    wait_idle(300, "init");
    checks++;
    if (mon_code.size() != 16) begin fails++; $display("FAIL init_count: got %0d bus cycles required 16", mon_code.size()); end
    for (int i = 0; i < 16 && i < mon_code.size(); i++) begin
      checks++;
      if (mon_code[i] !== ((i % 2 == 0) ? 2'b11 : 2'b10) || mon_data[i] !== init_exp[i] ||
          mon_sel0[i] !== ((i < 8) ? 1'b1 : 1'b0) || mon_len[i] != 3 || mon_oe[i] !== 1'b1) begin
        fails++;
        $display("FAIL init_cycle%0d: got code=%b data=%h sel0=%b len=%0d oe=%b required code=%b data=%h sel0=%b len=3 oe=1",
                 i, mon_code[i], mon_data[i], mon_sel0[i], mon_len[i], mon_oe[i],
                 (i % 2 == 0) ? 2'b11 : 2'b10, init_exp[i], (i < 8) ? 1'b1 : 1'b0);
      end
    end
    checks++; if (ym_sel0 !== 1'b1) begin fails++; $display("FAIL init_sel_restore: got sel0=%b required 1", ym_sel0); end
  endtask

  task automatic test_addr_data();
    logic [1:0] exp_code;
    logic       exp_oe;
    @(negedge cpu_clock);
    req_stb = 1'b1; req_kind = 2'd0; req_data = 8'h07;
    for (int s = 0; s < 13; s++) begin
      @(negedge cpu_clock);
      exp_code = (s >= 2 && s <= 4) ? 2'b11 : (s >= 8 && s <= 10) ? 2'b10 : 2'b00;
      exp_oe   = ((s >= 1 && s <= 5) || (s >= 7 && s <= 11)) ? 1'b1 : 1'b0;
      checks++;
      if ({ym_bdir, ym_bc1} !== exp_code || ym_da_oe !== exp_oe) begin
        fails++;
        $display("FAIL addr_data_s%0d: got code=%b oe=%b required code=%b oe=%b", s, {ym_bdir, ym_bc1}, ym_da_oe, exp_code, exp_oe);
      end
      if (exp_oe) begin
        checks++;
        if (ym_da_out !== ((s <= 5) ? 8'h07 : 8'h38)) begin
          fails++;
          $display("FAIL addr_data_bus_s%0d: got %h required %h", s, ym_da_out, (s <= 5) ? 8'h07 : 8'h38);
        end
      end
      if (s == 0) begin req_kind = 2'd1; req_data = 8'h38; end
      if (s == 1) req_stb = 1'b0;
    end
    wait_idle(50, "addr_data");
  endtask

  task automatic test_chip_select();
    clear_monitor();
    send_req(2'd0, 8'hFF);
    send_req(2'd0, 8'h01);
    send_req(2'd1, 8'h55);
    send_req(2'd0, 8'hFE);
    send_req(2'd0, 8'h07);
    wait_idle(100, "chip_select");
    checks++;
    if (mon_code.size() != 3) begin
      fails++; $display("FAIL cs_count: got %0d bus cycles required 3", mon_code.size());
    end else begin
      checks++;
      if (mon_code[0] !== 2'b11 || mon_data[0] !== 8'h01 || mon_sel0[0] !== 1'b0) begin
        fails++; $display("FAIL cs_latch01: got code=%b data=%h sel0=%b required 11/01/0", mon_code[0], mon_data[0], mon_sel0[0]);
      end
      checks++;
      if (mon_code[1] !== 2'b10 || mon_data[1] !== 8'h55 || mon_sel0[1] !== 1'b0) begin
        fails++; $display("FAIL cs_write55: got code=%b data=%h sel0=%b required 10/55/0", mon_code[1], mon_data[1], mon_sel0[1]);
      end
      checks++;
      if (mon_code[2] !== 2'b11 || mon_data[2] !== 8'h07 || mon_sel0[2] !== 1'b1) begin
        fails++; $display("FAIL cs_back_to_chip0: got code=%b data=%h sel0=%b required 11/07/1", mon_code[2], mon_data[2], mon_sel0[2]);
      end
    end
    checks++; if (ym_sel1 !== 1'b0) begin fails++; $display("FAIL cs_sel1: got %b required 0", ym_sel1); end
  endtask

  task automatic test_read();
    clear_monitor();
    ym_da_in = 8'hA5;
    oe_seen  = 0;
    rv_count = 0;
    send_req(2'd2, 8'h00);
    wait_idle(50, "read");
    ym_da_in = 8'h00;
    checks++;
    if (mon_code.size() != 1 || mon_code[0] !== 2'b01) begin
      fails++; $display("FAIL read_code: got %0d cycles first code=%b required 1 cycle code 01", mon_code.size(), (mon_code.size() > 0) ? mon_code[0] : 2'bxx);
    end
    checks++; if (oe_seen != 0) begin fails++; $display("FAIL read_oe: got %0d driven cycles required 0", oe_seen); end
    checks++; if (rd_data !== 8'hA5) begin fails++; $display("FAIL read_data: got %h required A5", rd_data); end
    checks++; if (rv_count != 1) begin fails++; $display("FAIL read_valid: got %0d pulses required 1", rv_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [0:4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(negedge cpu_clock);
    reset = 1'b0;
    @(negedge cpu_clock);
    clear_monitor();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_stb = 1'b1; req_kind = 2'd1; req_data = vals[i];
      @(negedge cpu_clock);
      if (i == 2) begin
        checks++; if (q_full !== 1'b0) begin fails++; $display("FAIL ovf_not_full_at3: got %b required 0", q_full); end
      end
      if (i == 3) begin
        checks++; if (q_full !== 1'b1) begin fails++; $display("FAIL ovf_full_at4: got %b required 1", q_full); end
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b required 0", ovf); end
      end
      if (i == 4) begin
        checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b required 1", ovf); end
      end
    end
    req_stb = 1'b0;
    wait_idle(400, "overflow");
    checks++;
    if (mon_code.size() != 20) begin
      fails++; $display("FAIL ovf_drain_count: got %0d bus cycles required 20", mon_code.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mon_code[16+i] !== 2'b10 || mon_data[16+i] !== vals[i]) begin
          fails++; $display("FAIL ovf_drain%0d: got code=%b data=%h required 10/%h", i, mon_code[16+i], mon_data[16+i], vals[i]);
        end
      end
    end
    checks++; if ({q_full, ovf} !== 2'b01) begin fails++; $display("FAIL ovf_after_drain: got q_full=%b ovf=%b required 0/1", q_full, ovf); end
  endtask

  task automatic test_mid_reset();
    int n;
    send_req(2'd0, 8'h07);
    n = 0;
    while ({ym_bdir, ym_bc1} !== 2'b11 && n < 20) begin
      @(negedge cpu_clock);
      n++;
    end
    checks++;
    if ({ym_bdir, ym_bc1} !== 2'b11) begin fails++; $display("FAIL midrst_strobe_seen: got %b required 11", {ym_bdir, ym_bc1}); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ym_bdir, ym_bc1, ym_da_oe} !== 3'b000) begin
      fails++; $display("FAIL midrst_async: got bdir=%b bc1=%b oe=%b required 000", ym_bdir, ym_bc1, ym_da_oe);
    end
    checks++; if ({ovf, busy} !== 2'b01) begin fails++; $display("FAIL midrst_flags: got ovf=%b busy=%b required 0/1", ovf, busy); end
    repeat (2) @(negedge cpu_clock);
    clear_monitor();
    reset = 1'b1;
    wait_idle(300, "mid_reset");
    checks++;
    if (mon_code.size() != 16 || mon_code[0] !== 2'b11 || mon_data[0] !== 8'h07) begin
      fails++; $display("FAIL midrst_reinit: got %0d cycles required 16 starting 11/07", mon_code.size());
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_addr_data();
    test_chip_select();
    test_read();
    test_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
